// File: rtl/vec_demux3_1_reg.sv
// vec_demux3_1_reg
//   Registered 1-to-3 vector demultiplexer. One M-lane x N-bit source is routed
//   to destination A, B or C by a 2-bit select. Each destination has a
//   one-entry output register (slot), so sustained throughput is one vector
//   per cycle per destination. A select of 11 is consumed and discarded. Each
//   such drop is counted in a saturating counter and raises a sticky error flag.
//
//   Optional build macro: VEC_DEMUX_LANE_MASK_EN
//     When defined, a lane_mask [M-1:0] input is added. On an accept, only
//     the lanes whose mask bit is 1 are written. The slot still becomes FULL
//     for any mask value, including 0.
//
//   Ports
//     clk, rst                       clock, async active-high reset
//     in_valid/in_ready/in_sel/in_data   source handshake, select, vector
//     lane_mask                      per-lane write enable (macro only)
//     out_{a,b,c}_valid/ready/data   destination handshakes + registered data
//     drop_count                     saturating count of sel=11 accepts
//     err_sel                        sticky, set on first sel=11 accept

// One destination slot: a FULL/EMPTY flag plus the data register.
module vec_demux3_1_reg_slot #(
  parameter int N = 16,
  parameter int M = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic                i_ready,
  input  logic [M-1:0]        i_mask,
  input  logic [M-1:0][N-1:0] i_data,
  output logic                o_valid,
  output logic                o_free,
  output logic [M-1:0][N-1:0] o_data
);
  logic                r_full;
  logic [M-1:0][N-1:0] r_data;

  // A load takes priority over a drain, so a simultaneous drain and load
  // leaves the slot FULL with the new vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_full <= 1'b0;
    else if (i_load) r_full <= 1'b1;
    else if (i_ready) r_full <= 1'b0;
  end

  // Masked-off lanes keep their previous value. On a drain the data
  // register is left as is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_data <= '0;
    else if (i_load) begin
      for (int i = 0; i < M; i++)
        if (i_mask[i]) r_data[i] <= i_data[i];
    end
  end

  assign o_valid = r_full;
  assign o_free  = ~r_full | i_ready;
  assign o_data  = r_data;
endmodule

module vec_demux3_1_reg #(
  parameter int N  = 16,
  parameter int M  = 16,
  parameter int CW = 8
) (
  input  logic                clk,
  input  logic                rst,
`ifdef VEC_DEMUX_LANE_MASK_EN
  input  logic [M-1:0]        lane_mask,
`endif
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_sel,
  input  logic [M-1:0][N-1:0] in_data,
  output logic                out_a_valid,
  input  logic                out_a_ready,
  output logic [M-1:0][N-1:0] out_a_data,
  output logic                out_b_valid,
  input  logic                out_b_ready,
  output logic [M-1:0][N-1:0] out_b_data,
  output logic                out_c_valid,
  input  logic                out_c_ready,
  output logic [M-1:0][N-1:0] out_c_data,
  output logic [CW-1:0]       drop_count,
  output logic                err_sel
);
  logic [2:0]                w_free;
  logic [2:0]                w_valid;
  logic [2:0]                w_rdy;
  logic [2:0]                w_load;
  logic [2:0][M-1:0][N-1:0]  w_data;
  logic [M-1:0]              w_mask;
  logic                      w_acc;
  logic [CW-1:0]             r_drop;
  logic                      r_err;

`ifdef VEC_DEMUX_LANE_MASK_EN
  assign w_mask = lane_mask;
`else
  assign w_mask = '1;
`endif

  assign w_rdy = {out_c_ready, out_b_ready, out_a_ready};

  // in_ready depends only on the select and the slot state, never on
  // in_valid. The drop path (sel=11) is always ready.
  always_comb begin
    in_ready = 1'b1;
    case (in_sel)
      2'd0:    in_ready = w_free[0];
      2'd1:    in_ready = w_free[1];
      2'd2:    in_ready = w_free[2];
      default: in_ready = 1'b1;
    endcase
  end

  assign w_acc = in_valid & in_ready;

  for (genvar g = 0; g < 3; g++) begin : g_slot
    assign w_load[g] = w_acc & (in_sel == 2'(g));
    vec_demux3_1_reg_slot #(.N(N), .M(M)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load[g]),
      .i_ready (w_rdy[g]),
      .i_mask  (w_mask),
      .i_data  (in_data),
      .o_valid (w_valid[g]),
      .o_free  (w_free[g]),
      .o_data  (w_data[g])
    );
  end

  // Dropped vectors (sel=11): the counter saturates and does not wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop <= '0;
      r_err  <= 1'b0;
    end else if (w_acc && in_sel == 2'd3) begin
      if (r_drop != {CW{1'b1}}) r_drop <= r_drop + 1'b1;
      r_err <= 1'b1;
    end
  end

  assign out_a_valid = w_valid[0];
  assign out_b_valid = w_valid[1];
  assign out_c_valid = w_valid[2];
  assign out_a_data  = w_data[0];
  assign out_b_data  = w_data[1];
  assign out_c_data  = w_data[2];
  assign drop_count  = r_drop;
  assign err_sel     = r_err;
endmodule

// File: tb/tb_vec_demux3_1_reg.sv
module tb_vec_demux3_1_reg;
  localparam int N  = 16;
  localparam int M  = 16;
  localparam int CW = 8;
  typedef logic [M-1:0][N-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_sel = 2'd0;
  vec_t          in_data = '0;
  logic [M-1:0]  mask = '1;
  logic          out_a_valid, out_b_valid, out_c_valid;
  logic          out_a_ready = 1'b0, out_b_ready = 1'b0, out_c_ready = 1'b0;
  vec_t          out_a_data, out_b_data, out_c_data;
  logic [CW-1:0] drop_count;
  logic          err_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vec_demux3_1_reg #(.N(N), .M(M), .CW(CW)) dut (
    .clk(clk), .rst(rst),
`ifdef VEC_DEMUX_LANE_MASK_EN
    .lane_mask(mask),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_data(out_a_data),
    .out_b_valid(out_b_valid), .out_b_ready(out_b_ready), .out_b_data(out_b_data),
    .out_c_valid(out_c_valid), .out_c_ready(out_c_ready), .out_c_data(out_c_data),
    .drop_count(drop_count), .err_sel(err_sel)
  );

  logic [2:0] ov, ordy;
  vec_t       od [3];
  assign ov   = {out_c_valid, out_b_valid, out_a_valid};
  assign ordy = {out_c_ready, out_b_ready, out_a_ready};
  assign od[0] = out_a_data;
  assign od[1] = out_b_data;
  assign od[2] = out_c_data;

  // Scoreboard. At the mid-cycle edge, a valid slot must present the head
  // of its queue, and a handshake pops that head. An accept pushes the
  // model register after the lane mask is applied.
  vec_t sb [3][$];
  vec_t mdl [3];

  always @(negedge clk) begin
    if (rst) begin
      for (int s = 0; s < 3; s++) begin
        sb[s].delete();
        mdl[s] = '0;
      end
    end else begin
      for (int s = 0; s < 3; s++) begin
        if (ov[s]) begin
          checks++;
          if (sb[s].size() == 0) begin
            errors++;
            $display("FAIL sb_slot%0d: valid=1 required no pending vector", s);
          end else begin
            if (od[s] !== sb[s][0]) begin
              errors++;
              $display("FAIL sb_slot%0d_data: got %h want %h", s, od[s], sb[s][0]);
            end
            if (ordy[s]) void'(sb[s].pop_front());
          end
        end
      end
      if (in_valid && in_ready && in_sel != 2'd3) begin
        for (int i = 0; i < M; i++)
          if (mask[i]) mdl[in_sel][i] = in_data[i];
        sb[in_sel].push_back(mdl[in_sel]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_all();
    in_valid = 1'b0;
    out_a_ready = 1'b1; out_b_ready = 1'b1; out_c_ready = 1'b1;
    tick();
    out_a_ready = 1'b0; out_b_ready = 1'b0; out_c_ready = 1'b0;
  endtask

  function automatic vec_t mkvec(input logic [N-1:0] base);
    vec_t v;
    for (int i = 0; i < M; i++) v[i] = base + N'(i);
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (ov !== 3'b000 || out_a_data !== '0 || out_b_data !== '0 || out_c_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid %b, required 000 with zero data", ov);
    end
    checks++;
    if (drop_count !== '0 || err_sel !== 1'b0) begin
      errors++;
      $display("FAIL reset_counters: drop %0d err %b, required 0 0", drop_count, err_sel);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    vec_t v1, v2;
    v1 = mkvec(16'h0001);
    v2 = mkvec(16'h0100);
    in_valid = 1'b1; in_sel = 2'd1; in_data = v1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_b_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pre: in_ready %b out_b_valid %b, required 1 0", in_ready, out_b_valid);
    end
    tick();
    checks++;
    if (ov !== 3'b010 || out_b_data !== v1) begin
      errors++;
      $display("FAIL single_latency: valid %b data %h, required 010 %h", ov, out_b_data, v1);
    end
    in_data = v2;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_block: in_ready %b, required 0", in_ready);
    end
    tick();
    checks++;
    if (out_b_valid !== 1'b1 || out_b_data !== v1) begin
      errors++;
      $display("FAIL single_hold: data %h, required %h", out_b_data, v1);
    end
    drain_all();
  endtask

  task automatic test_back_to_back();
    out_a_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_sel = 2'd0;
      in_data = mkvec(16'($urandom));
      in_data[0] = N'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready_%0d: in_ready %b, required 1", i, in_ready);
      end
      tick();
      checks++;
      if (out_a_valid !== 1'b1 || out_a_data[0] !== N'(i)) begin
        errors++;
        $display("FAIL b2b_lane0_%0d: valid %b lane0 %0d, required 1 %0d",
                 i, out_a_valid, out_a_data[0], i);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_a_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: out_a_valid %b, required 0", out_a_valid);
    end
    drain_all();
  endtask

  task automatic test_independent();
    vec_t vb, vc;
    vb = mkvec(16'h0B00);
    vc = mkvec(16'h0C00);
    in_valid = 1'b1; in_sel = 2'd1; in_data = vb;
    tick();
    in_sel = 2'd2; in_data = vc; out_c_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL indep_c_ready: in_ready %b, required 1", in_ready);
    end
    tick();
    checks++;
    if (ov !== 3'b110 || out_c_data !== vc || out_b_data !== vb) begin
      errors++;
      $display("FAIL indep_both: valid %b, required 110 with B and C data", ov);
    end
    in_valid = 1'b0; out_b_ready = 1'b1;
    tick();
    checks++;
    if (ov !== 3'b000) begin
      errors++;
      $display("FAIL indep_drain: valid %b, required 000", ov);
    end
    drain_all();
  endtask

  task automatic test_invalid_sel();
    in_valid = 1'b1; in_sel = 2'd3;
    for (int i = 0; i < 5; i++) begin in_data = mkvec(16'($urandom)); tick(); end
    in_valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (drop_count !== 8'd5 || err_sel !== 1'b1) begin
      errors++;
      $display("FAIL drop_partial: drop %0d err %b, required 5 1", drop_count, err_sel);
    end
    in_valid = 1'b1;
    for (int i = 5; i < 300; i++) begin
      #1;
      if (in_ready !== 1'b1 || ov !== 3'b000) begin
        checks++; errors++;
        $display("FAIL drop_cycle_%0d: in_ready %b valid %b, required 1 000", i, in_ready, ov);
      end
      tick();
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (drop_count !== 8'd255 || err_sel !== 1'b1 || ov !== 3'b000) begin
      errors++;
      $display("FAIL drop_sat: drop %0d err %b valid %b, required 255 1 000",
               drop_count, err_sel, ov);
    end
  endtask

  task automatic test_async_reset();
    vec_t vz;
    vz = mkvec(16'h0D00);
    in_valid = 1'b1; in_sel = 2'd0; in_data = mkvec(16'h0A00);
    tick();
    in_sel = 2'd2; in_data = mkvec(16'h0E00);
    tick();
    in_valid = 1'b0;
    checks++;
    if (ov !== 3'b101) begin
      errors++;
      $display("FAIL areset_pre: valid %b, required 101", ov);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ov !== 3'b000 || out_a_data !== '0 || out_c_data !== '0 ||
        drop_count !== '0 || err_sel !== 1'b0) begin
      errors++;
      $display("FAIL areset_now: valid %b drop %0d err %b, required 000 0 0",
               ov, drop_count, err_sel);
    end
    tick();
    rst = 1'b0;
    in_valid = 1'b1; in_sel = 2'd0; in_data = vz;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_a_valid !== 1'b1 || out_a_data !== vz) begin
      errors++;
      $display("FAIL areset_after: valid %b data %h, required 1 %h", out_a_valid, out_a_data, vz);
    end
    drain_all();
  endtask

`ifdef VEC_DEMUX_LANE_MASK_EN
  task automatic test_lane_mask();
    vec_t want;
    in_valid = 1'b1; in_sel = 2'd0; in_data = {M{16'hAAAA}}; mask = '1;
    tick();
    in_valid = 1'b0; out_a_ready = 1'b1;
    tick();
    out_a_ready = 1'b0;
    in_valid = 1'b1; in_data = {M{16'h5555}}; mask = 16'h00FF;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < M; i++) want[i] = (i < 8) ? 16'h5555 : 16'hAAAA;
    checks++;
    if (out_a_valid !== 1'b1 || out_a_data !== want) begin
      errors++;
      $display("FAIL mask_lanes: valid %b data %h, required 1 %h", out_a_valid, out_a_data, want);
    end
    mask = '0; out_a_ready = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; out_a_ready = 1'b0;
    checks++;
    if (out_a_valid !== 1'b1 || out_a_data !== want) begin
      errors++;
      $display("FAIL mask_zero: valid %b, required 1 and unchanged data", out_a_valid);
    end
    mask = '1;
    drain_all();
  endtask
`endif

  task automatic test_final();
    tick();
    checks++;
    if (ov !== 3'b000 || sb[0].size() != 0 || sb[1].size() != 0 || sb[2].size() != 0) begin
      errors++;
      $display("FAIL final_empty: valid %b queues %0d %0d %0d, required all 0",
               ov, sb[0].size(), sb[1].size(), sb[2].size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_independent();
    test_invalid_sel();
    test_async_reset();
`ifdef VEC_DEMUX_LANE_MASK_EN
    test_lane_mask();
`endif
    test_final();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
